// File: rtl/atomic_alu_arbiter_if.sv
// Requester, response and ALU-side signals of atomic_alu_arbiter.
// The arbiter uses the slave view; the requesters plus the ALU use the master view.
interface atomic_alu_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int W     = 32
);
   logic [N_REQ-1:0]    req;
   logic [N_REQ*12-1:0] cmd;
   logic [N_REQ-1:0]    gnt;
   logic [N_REQ-1:0]    resp_valid;
   logic [W-1:0]        resp_data;
   logic [3:0]          resp_flags;
   logic [2:0]          alu_op_code;
   logic [W-1:0]        data_a;
   logic [W-1:0]        data_b;
   logic [W-1:0]        y;
   logic                O;
   logic                C;
   logic                Z;
   logic                N;

   modport slave (
      input  req, cmd, y, O, C, Z, N,
      output gnt, resp_valid, resp_data, resp_flags, alu_op_code, data_a, data_b
   );

   modport master (
      output req, cmd, y, O, C, Z, N,
      input  gnt, resp_valid, resp_data, resp_flags, alu_op_code, data_a, data_b
   );
endinterface

// File: rtl/atomic_alu_arbiter.sv
// Round-robin arbiter sharing one external ALU and an 8xW register file; every
// command runs read -> ALU -> writeback as an indivisible IDLE/EXEC/COMMIT pass.
module atomic_alu_arbiter #(
   parameter int N_REQ = 4,
   parameter int W     = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   atomic_alu_arbiter_if.slave bus
);
   localparam int               PW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [2:0]       OP_SUB = 3'b001;
   localparam logic [2:0]       OP_CAS = 3'b111;
   localparam logic [N_REQ-1:0] ONE    = 1;

   typedef enum logic [1:0] {IDLE, EXEC, COMMIT} state_t;

   state_t        state, state_nxt;
   logic [PW-1:0] ptr, idx_q, win_idx;
   logic          win_found;
   logic [11:0]   win_cmd, cmd_q;
   logic [W-1:0]  rf [8];
   logic [2:0]    w_op, w_a1, w_a2, w_a3;
   logic [2:0]    q_op, q_a1, q_a2, q_a3;
   logic          q_cas;

   assign win_cmd                  = bus.cmd[12*int'(win_idx) +: 12];
   assign {w_op, w_a1, w_a2, w_a3} = win_cmd;
   assign {q_op, q_a1, q_a2, q_a3} = cmd_q;
   assign q_cas                    = (q_op == OP_CAS);

   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= N_REQ) s = s - N_REQ;
      return PW'(s);
   endfunction

   // Scan from the far end back toward ptr so the requester closest to ptr wins.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      win_found = 1'b0;
      win_idx   = ptr;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (bus.req[wrap_add(ptr, k)]) begin
            win_found = 1'b1;
            win_idx   = wrap_add(ptr, k);
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      bus.gnt   = '0;
      case (state)
         IDLE: begin
            if (win_found) begin
               state_nxt = EXEC;
               bus.gnt   = rst_n ? (ONE << win_idx) : '0;
            end
         end
         EXEC:    state_nxt = COMMIT;
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // resp_data/resp_flags double as the holding registers for y and the flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr             <= '0;
         idx_q           <= '0;
         cmd_q           <= '0;
         bus.resp_valid  <= '0;
         bus.resp_data   <= '0;
         bus.resp_flags  <= '0;
         bus.alu_op_code <= '0;
         bus.data_a      <= '0;
         bus.data_b      <= '0;
         // NOTE: the register file is architecturally visible state, so it is reset too.
         for (int k = 0; k < 8; k++) rf[k] <= '0;
      end else begin
         bus.resp_valid  <= '0;
         bus.resp_data   <= '0;
         bus.resp_flags  <= '0;
         bus.alu_op_code <= '0;
         bus.data_a      <= '0;
         bus.data_b      <= '0;
         case (state)
            IDLE: begin
               if (win_found) begin
                  cmd_q           <= win_cmd;
                  idx_q           <= win_idx;
                  bus.alu_op_code <= (w_op == OP_CAS) ? OP_SUB : w_op;
                  bus.data_a      <= rf[w_a1];
                  bus.data_b      <= (w_op == OP_CAS) ? rf[w_a3] : rf[w_a2];
               end
            end
            EXEC: begin
               bus.resp_valid <= ONE << idx_q;
               bus.resp_data  <= q_cas ? {{(W-1){1'b0}}, bus.Z} : bus.y;
               bus.resp_flags <= {bus.O, bus.C, bus.Z, bus.N};
            end
            COMMIT: begin
               if (!q_cas)                rf[q_a3] <= bus.resp_data;
               else if (bus.resp_flags[1]) rf[q_a1] <= rf[q_a2];
               else                       rf[q_a3] <= rf[q_a1];
               ptr <= wrap_add(idx_q, 1);
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_atomic_alu_arbiter.sv
// Randomised bench for atomic_alu_arbiter: a behavioural ALU drives y/flags and a
// register-file/round-robin model predicts grants, ALU operands and responses.
module tb_atomic_alu_arbiter;
   localparam int N_REQ = 4;
   localparam int W     = 32;

   logic clk = 1'b0;
   logic rst_n;

   atomic_alu_arbiter_if #(.N_REQ(N_REQ), .W(W)) bus ();

   atomic_alu_arbiter #(.N_REQ(N_REQ), .W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // ALU map: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shift-left-1, 6 increment.
   function automatic logic [35:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [32:0] s;
      logic [31:0] r;
      logic        o, c;
      s = '0; r = '0; o = 1'b0; c = 1'b0;
      case (op)
         3'd0: begin
            s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
            o = (a[31] == b[31]) && (r[31] != a[31]);
         end
         3'd1: begin
            s = {1'b0, a} - {1'b0, b}; r = s[31:0]; c = s[32];
            o = (a[31] != b[31]) && (r[31] != a[31]);
         end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: begin r = {a[30:0], 1'b0}; c = a[31]; end
         3'd6: begin s = {1'b0, a} + 33'd1; r = s[31:0]; c = s[32]; o = !a[31] && r[31]; end
         default: r = '0;
      endcase
      return {o, c, (r == 32'd0), r[31], r};
   endfunction

   assign {bus.O, bus.C, bus.Z, bus.N, bus.y} = alu_ref(bus.alu_op_code, bus.data_a, bus.data_b);

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   logic [31:0] m_rf [8];
   int          m_ptr;
   logic [11:0] cmd_of [N_REQ];
   int          grant_log [$];
   logic [31:0] resp_log [$];
   logic [31:0] last_resp;
   logic [3:0]  last_flags;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_gnt"},        32'(bus.gnt),         0);
      check({tag, "_resp_valid"}, 32'(bus.resp_valid),  0);
      check({tag, "_resp_data"},  bus.resp_data,        0);
      check({tag, "_resp_flags"}, 32'(bus.resp_flags),  0);
      check({tag, "_alu_op"},     32'(bus.alu_op_code), 0);
      check({tag, "_data_a"},     bus.data_a,           0);
      check({tag, "_data_b"},     bus.data_b,           0);
   endtask

   task automatic model_reset();
      for (int r = 0; r < 8; r++) m_rf[r] = '0;
      m_ptr = 0;
   endtask

   function automatic int rr_pick(input int base, input logic [3:0] pend);
      for (int k = 0; k < N_REQ; k++)
         if (pend[(base + k) % N_REQ]) return (base + k) % N_REQ;
      return -1;
   endfunction

   task automatic set_cmd(input int i, input logic [11:0] c);
      cmd_of[i]          = c;
      bus.cmd[12*i +: 12] = c;
   endtask

   // Raise the requesters in mask and follow n grants through EXEC and COMMIT.
   task automatic serve(input logic [3:0] mask, input logic [3:0] hold, input int n);
      logic [3:0]  pend;
      int          w, waited, last_t;
      logic [2:0]  op, a1, a2, a3, eop;
      logic [31:0] ea, eb, exp_d;
      logic [35:0] r;
      logic        cas, match;
      pend    = mask;
      last_t  = 0;
      bus.req = pend;
      for (int k = 0; k < n; k++) begin
         w = rr_pick(m_ptr, pend);
         if (w < 0) w = 0;
         waited = 0;
         @(negedge clk);
         while (bus.gnt == '0 && waited < 20) begin
            @(negedge clk);
            waited++;
         end
         check("gnt", 32'(bus.gnt), 32'(1) << w);
         if (bus.gnt == '0) begin
            bus.req = '0;
            return;
         end
         if (k > 0) check("gnt_spacing", cyc - last_t, 3);
         last_t = cyc;
         check("idle_resp_valid", 32'(bus.resp_valid), 0);
         check("idle_alu_op", 32'(bus.alu_op_code), 0);
         grant_log.push_back(w);

         {op, a1, a2, a3} = cmd_of[w];
         cas   = (op == 3'b111);
         ea    = m_rf[a1];
         eb    = cas ? m_rf[a3] : m_rf[a2];
         eop   = cas ? 3'b001 : op;
         r     = alu_ref(eop, ea, eb);
         match = (m_rf[a1] == m_rf[a3]);
         exp_d = cas ? 32'(match) : r[31:0];

         @(posedge clk);
         #1;
         if (k == n - 1)   pend = '0;
         else if (!hold[w]) pend[w] = 1'b0;
         bus.req = pend;

         @(negedge clk);
         check("exec_alu_op", 32'(bus.alu_op_code), 32'(eop));
         check("exec_data_a", bus.data_a, ea);
         check("exec_data_b", bus.data_b, eb);
         check("exec_gnt", 32'(bus.gnt), 0);
         check("exec_resp_valid", 32'(bus.resp_valid), 0);

         @(negedge clk);
         check("commit_resp_valid", 32'(bus.resp_valid), 32'(1) << w);
         check("commit_resp_data", bus.resp_data, exp_d);
         check("commit_resp_flags", 32'(bus.resp_flags), 32'(r[35:32]));
         check("commit_alu_op", 32'(bus.alu_op_code), 0);
         check("commit_data_a", bus.data_a, 0);

         if (!cas)      m_rf[a3] = r[31:0];
         else if (match) m_rf[a1] = m_rf[a2];
         else           m_rf[a3] = m_rf[a1];
         m_ptr      = (w + 1) % N_REQ;
         last_resp  = bus.resp_data;
         last_flags = bus.resp_flags;
         resp_log.push_back(bus.resp_data);
      end
      bus.req = '0;
   endtask

   task automatic do_cmd(input int i, input logic [11:0] c);
      set_cmd(i, c);
      serve(4'(1 << i), 4'b0000, 1);
   endtask

   task automatic read_reg(input int r, output logic [31:0] v);
      do_cmd(3, {3'd3, 3'(r), 3'(r), 3'(r)});
      v = last_resp;
   endtask

   // Clear with r-r, then build the value MSB-first with shift and increment.
   task automatic set_reg(input int r, input logic [31:0] v);
      logic started;
      started = 1'b0;
      do_cmd(3, {3'd1, 3'(r), 3'(r), 3'(r)});
      for (int b = 31; b >= 0; b--) begin
         if (started) do_cmd(3, {3'd5, 3'(r), 3'(r), 3'(r)});
         if (v[b]) begin
            do_cmd(3, {3'd6, 3'(r), 3'(r), 3'(r)});
            started = 1'b1;
         end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int          waited;
      logic [31:0] v;
      logic [3:0]  mask, hold;
      int          n;

      rst_n   = 1'b0;
      bus.req = '0;
      bus.cmd = '0;
      for (int i = 0; i < N_REQ; i++) cmd_of[i] = '0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_quiet("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;

      // First command after reset: r1 + r2 -> r3 on an all-zero file.
      do_cmd(0, {3'd0, 3'd1, 3'd2, 3'd3});
      check("first_add_resp", last_resp, 0);
      read_reg(3, v);
      check("first_add_r3", v, 0);

      // Reset during EXEC aborts the command and clears the file.
      set_reg(1, 32'd5);
      set_cmd(0, {3'd6, 3'd1, 3'd0, 3'd1});
      bus.req = 4'b0001;
      waited  = 0;
      @(negedge clk);
      while (bus.gnt == '0 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("abort_gnt", 32'(bus.gnt), 1);
      @(posedge clk);
      #1;
      bus.req = '0;
      rst_n   = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_quiet("abort");
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      check("abort_resp_valid_after", 32'(bus.resp_valid), 0);
      read_reg(1, v);
      check("abort_r1_cleared", v, 0);

      // ALU latency and operands.
      set_reg(1, 32'd5);
      set_reg(2, 32'd7);
      do_cmd(2, {3'd0, 3'd1, 3'd2, 3'd4});
      check("add_5_7_resp", last_resp, 12);
      read_reg(4, v);
      check("add_5_7_r4", v, 12);

      // CAS success.
      set_reg(1, 32'd10);
      set_reg(2, 32'd99);
      set_reg(3, 32'd10);
      do_cmd(1, {3'd7, 3'd1, 3'd2, 3'd3});
      check("cas_ok_resp", last_resp, 1);
      read_reg(1, v);
      check("cas_ok_r1", v, 99);
      read_reg(3, v);
      check("cas_ok_r3", v, 10);

      // CAS failure.
      set_reg(1, 32'd10);
      set_reg(3, 32'd4);
      do_cmd(1, {3'd7, 3'd1, 3'd2, 3'd3});
      check("cas_fail_resp", last_resp, 0);
      check("cas_fail_z", 32'(last_flags[1]), 0);
      read_reg(3, v);
      check("cas_fail_r3", v, 10);
      read_reg(1, v);
      check("cas_fail_r1", v, 10);

      // Round-robin with all four requests held (ptr is 0 after requester 3).
      for (int i = 0; i < N_REQ; i++) set_cmd(i, 12'($urandom));
      grant_log.delete();
      serve(4'hF, 4'hF, 8);
      check("rr_count", grant_log.size(), 8);
      if (grant_log.size() == 8)
         for (int j = 0; j < 8; j++) check("rr_order", grant_log[j], j % N_REQ);

      // Two simultaneous CAS on R1: only the first in round-robin order wins.
      set_reg(1, 32'd0);
      set_reg(5, 32'd1);
      set_reg(6, 32'd2);
      set_reg(3, 32'd0);
      set_reg(4, 32'd0);
      set_cmd(0, {3'd7, 3'd1, 3'd5, 3'd3});
      set_cmd(1, {3'd7, 3'd1, 3'd6, 3'd4});
      grant_log.delete();
      resp_log.delete();
      serve(4'b0011, 4'b0000, 2);
      check("race_count", grant_log.size(), 2);
      if (grant_log.size() == 2 && resp_log.size() == 2) begin
         check("race_first_idx", grant_log[0], 0);
         check("race_first_resp", resp_log[0], 1);
         check("race_second_idx", grant_log[1], 1);
         check("race_second_resp", resp_log[1], 0);
      end
      read_reg(1, v);
      check("race_r1", v, 1);
      read_reg(4, v);
      check("race_r4", v, 1);

      // Random traffic over a randomly seeded file.
      for (int r = 0; r < 8; r++) set_reg(r, 32'($urandom_range(0, 65535)));
      for (int it = 0; it < 40; it++) begin
         mask = 4'($urandom_range(1, 15));
         hold = 4'($urandom) & mask;
         for (int i = 0; i < N_REQ; i++) set_cmd(i, 12'($urandom));
         n = $countones(mask) + ((hold != 0) ? int'($urandom_range(0, 4)) : 0);
         serve(mask, hold, n);
      end

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/atomic_alu_arbiter.md
# atomic_alu_arbiter

Shares one combinational ALU and an 8×32 register file between `N_REQ` requesters. Each requester issues 12-bit commands: ALU ops, or an atomic compare-and-swap (CAS). Grants are round-robin. Every command runs read→ALU→writeback as one indivisible sequence, so no other requester can observe or modify the register file mid-operation. The block sits between the requester ports and the ALU, and owns the register file.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `W`, 32, data width

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `req`  in  N_REQ  per-requester request; held until granted
- `cmd`  in  N_REQ*12  per-requester command; slice i = `cmd[12*i+11:12*i]`
- `gnt`  out  N_REQ  one-hot, one-cycle grant pulse
- `resp_valid`  out  N_REQ  one-hot, one-cycle completion pulse
- `resp_data`  out  W  result: ALU `y`, or CAS success flag (1/0)
- `resp_flags`  out  4  {O,C,Z,N} captured from the ALU
- `alu_op_code`  out  3  ALU operation
- `data_a`, `data_b`  out  W  ALU operands
- `y`  in  W  ALU result, combinational from the operands
- `O`, `C`, `Z`, `N`  in  1  ALU flags, combinational

## Operation
- Command fields: op=[11:9], a1=[8:6], a2=[5:3], a3=[2:0].
- ALU op (op≠111):
  - `data_a`=R[a1], `data_b`=R[a2], `alu_op_code`=op.
  - R[a3] ← y.
  - resp_data=y.
- CAS (op=111):
  - `data_a`=R[a1] (target), `data_b`=R[a3] (expected), `alu_op_code`=001 (subtract).
  - Z=1 (match): R[a1] ← R[a2], resp_data=1.
  - Z=0 (mismatch): R[a3] ← R[a1] (expected register updated with the current value), resp_data=0.
  - If a1=a3: Z=1 always, so R[a1] ← R[a2].
- FSM states: IDLE, EXEC, COMMIT.
  - IDLE: if any `req` is high, grant the winner, latch its `cmd` and index, go to EXEC. Otherwise stay.
  - EXEC: drive `alu_op_code`/`data_a`/`data_b` from the latched command and the current register file. Capture `y` and flags into holding registers. Go to COMMIT.
  - COMMIT: perform the register write. Pulse `resp_valid[idx]` with `resp_data`/`resp_flags`. Advance the pointer. Go to IDLE.
- Round-robin:
  - Pointer `ptr` starts at 0.
  - Search order is ptr, ptr+1, …, wrapping modulo N_REQ.
  - After granting i, ptr ← (i+1) mod N_REQ.
- Requester rules:
  - `cmd[i]` must be stable while `req[i]` is high. It is sampled only in the `gnt` cycle.
  - A requester whose `req` stays high after its grant is re-arbitrated as a new command.
- Register file:
  - Only this block writes it.
  - At most one write per command, and only in COMMIT.

## Timing
- Reset (`rst_n`=0 at a clock edge): state=IDLE, ptr=0, all R[k]=0, holding registers cleared.
  - Outputs `gnt`, `resp_valid`, `resp_data`, `resp_flags`, `alu_op_code`, `data_a`, `data_b` are all 0.
- Reset mid-operation (in EXEC or COMMIT): abort. No writeback, no `resp_valid`, the pending command is lost.
- Cycle-level latency:
  - `gnt` at cycle T (IDLE).
  - ALU driven at T+1 (EXEC).
  - Writeback and `resp_valid` at T+2 (COMMIT).
  - Next grant no earlier than T+3.
  - Peak throughput is 1 command per 3 cycles.
- `alu_op_code`/`data_a`/`data_b` are registered. They are nonzero only during EXEC and are 0 in IDLE and COMMIT.
- `resp_data`/`resp_flags` are valid only while `resp_valid` is high, and 0 otherwise.
- A new `req` arriving during EXEC/COMMIT waits. It is eligible in the next IDLE cycle.
- The register file value written at T+2 is visible to a command granted at T+3, with no forwarding hazard.
- There is no timeout. A requester holding `req` is served within N_REQ commands (starvation-free).

## Test plan
- Reset: preload nothing, release `rst_n`. Requester 0 issues ADD (op per ALU map) r1+r2→r3 → `resp_valid[0]` at T+2, resp_data=0, R3=0. Assert `rst_n`=0 during EXEC → no `resp_valid`, all outputs 0 the next cycle.
- ALU op latency: seed R1=5, R2=7 via prior writes. Requester 2 ADD r1,r2→r4 → `gnt[2]` at T, `data_a`=5/`data_b`=7 at T+1, R4=12 and resp_data=12 at T+2.
- CAS success: R1=10, R2=99, R3=10. CAS a1=1,a2=2,a3=3 → `alu_op_code`=001 in EXEC, resp_data=1, R1=99, R3 unchanged.
- CAS failure: R1=10, R3=4 → resp_data=0, R3=10, R1 unchanged, resp_flags Z=0.
- Round-robin fairness: all 4 `req` held high continuously, ptr=0 → grants in order 0,1,2,3,0…, spaced exactly 3 cycles apart.
- Atomicity race: requesters 0 and 1 both CAS the same target R1=0 (expected 0, new 1 and new 2) in the same cycle → only requester 0 succeeds (resp_data=1). Requester 1 gets resp_data=0 and its expected register becomes 1. Final R1=1.
